// File: rtl/csr_write_unit.sv
// -----------------------------------------------------------------------------
// csr_write_unit
//   Write side of the machine-mode CSR file. Executes CSRRW/RS/RC (and the
//   immediate forms) as a read-modify-write over three cycles
//   (IDLE -> EXEC -> RESP). It owns the writable M-mode CSRs and the 64-bit
//   mcycle/minstret counters, and returns the old CSR value.
//
//   Optional feature macro: CSR_COUNTER_WRITE_EN
//     defined   : mcycle/mcycleh/minstret/minstreth (0xB00/0xB80/0xB02/0xB82)
//                 are readable and writable here.
//     undefined : those addresses are illegal; counters only reset/increment.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   csr_addr            12-bit CSR address
//   csr_funct3          001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
//   csr_src             rs1 value or zero-extended zimm
//   src_is_zero         rs1 index / zimm is zero (no write for RS/RC forms)
//   inc_instret         retire pulse
//   rsp_valid           one-cycle response pulse, 2 cycles after accept
//   rsp_rdata           old CSR value (0 when illegal)
//   rsp_illegal         illegal-instruction flag
//   cycle_o, instret_o  registered copies of mcycle / minstret
// -----------------------------------------------------------------------------
module csr_write_unit #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter int          CNT_W       = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [11:0]      csr_addr,
    input  logic [2:0]       csr_funct3,
    input  logic [31:0]      csr_src,
    input  logic             src_is_zero,
    input  logic             inc_instret,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_illegal,
    output logic [CNT_W-1:0] cycle_o,
    output logic [CNT_W-1:0] instret_o
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
`ifdef CSR_COUNTER_WRITE_EN
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
`endif

    localparam logic [31:0] M_MSTATUS = 32'h0000_0088;
    localparam logic [31:0] M_MIE     = 32'h0000_0888;
    localparam logic [31:0] M_MTVEC   = 32'hFFFF_FFFD;
    localparam logic [31:0] M_MEPC    = 32'hFFFF_FFFC;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // funct3[1:0] selects the operation; bit 2 (immediate form) only changes
    // where csr_src came from, so it is not needed past the port.
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

    state_e             state_q, state_d;
    logic [11:0]        req_addr_q, req_addr_d;
    logic [1:0]         req_op_q, req_op_d;
    logic [31:0]        req_src_q, req_src_d;
    logic               req_zero_q, req_zero_d;

    logic [31:0]        mstatus_q, mstatus_d;
    logic [31:0]        mie_q, mie_d;
    logic [31:0]        mtvec_q, mtvec_d;
    logic [31:0]        mscratch_q, mscratch_d;
    logic [31:0]        mepc_q, mepc_d;
    logic [31:0]        mcause_q, mcause_d;
    logic [31:0]        mtval_q, mtval_d;
    logic [CNT_W-1:0]   mcycle_q, mcycle_d;
    logic [CNT_W-1:0]   minstret_q, minstret_d;
    logic [CNT_W-1:0]   cycle_o_q, cycle_o_d;
    logic [CNT_W-1:0]   instret_o_q, instret_o_d;

    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_illegal_q, rsp_illegal_d;

    logic               hit;
    logic [31:0]        old_val;
    logic [31:0]        new_val;
    logic               wr_intent;
    logic               illegal;
    logic               do_wr;
    logic               unused_funct3;

    assign unused_funct3 = csr_funct3[2];

    // Decode of the latched request; only meaningful while in EXEC.
    always_comb begin
        hit     = 1'b1;
        old_val = 32'h0;
        case (req_addr_q)
            A_MSTATUS:   old_val = mstatus_q;
            A_MIE:       old_val = mie_q;
            A_MTVEC:     old_val = mtvec_q;
            A_MSCRATCH:  old_val = mscratch_q;
            A_MEPC:      old_val = mepc_q;
            A_MCAUSE:    old_val = mcause_q;
            A_MTVAL:     old_val = mtval_q;
`ifdef CSR_COUNTER_WRITE_EN
            // Pre-increment value of this cycle.
            A_MCYCLE:    old_val = mcycle_q[31:0];
            A_MCYCLEH:   old_val = mcycle_q[CNT_W-1:32];
            A_MINSTRET:  old_val = minstret_q[31:0];
            A_MINSTRETH: old_val = minstret_q[CNT_W-1:32];
`endif
            default:     hit = 1'b0;
        endcase

        // RS/RC with a zero source is a pure read.
        wr_intent = (req_op_q == OP_RW) || !req_zero_q;
        illegal   = !hit || (req_op_q == OP_NONE) ||
                    (wr_intent && (req_addr_q[11:10] == 2'b11));

        case (req_op_q)
            OP_RS:   new_val = old_val | req_src_q;
            OP_RC:   new_val = old_val & ~req_src_q;
            default: new_val = req_src_q;
        endcase

        do_wr = (state_q == S_EXEC) && !illegal && wr_intent;
    end

    always_comb begin
        state_d       = state_q;
        req_addr_d    = req_addr_q;
        req_op_d      = req_op_q;
        req_src_d     = req_src_q;
        req_zero_d    = req_zero_q;
        mstatus_d     = mstatus_q;
        mie_d         = mie_q;
        mtvec_d       = mtvec_q;
        mscratch_d    = mscratch_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mtval_d       = mtval_q;
        mcycle_d      = mcycle_q + CNT_ONE;
        minstret_d    = inc_instret ? (minstret_q + CNT_ONE) : minstret_q;
        cycle_o_d     = mcycle_q;
        instret_o_d   = minstret_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_illegal_d = rsp_illegal_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    req_addr_d = csr_addr;
                    req_op_d   = csr_funct3[1:0];
                    req_src_d  = csr_src;
                    req_zero_d = src_is_zero;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_rdata_d   = illegal ? 32'h0 : old_val;
                rsp_illegal_d = illegal;
                state_d       = S_RESP;
            end
            S_RESP: begin
                rsp_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (do_wr) begin
            case (req_addr_q)
                A_MSTATUS:   mstatus_d  = new_val & M_MSTATUS;
                A_MIE:       mie_d      = new_val & M_MIE;
                A_MTVEC:     mtvec_d    = new_val & M_MTVEC;
                A_MSCRATCH:  mscratch_d = new_val;
                A_MEPC:      mepc_d     = new_val & M_MEPC;
                A_MCAUSE:    mcause_d   = new_val;
                A_MTVAL:     mtval_d    = new_val;
`ifdef CSR_COUNTER_WRITE_EN
                // Software write wins over the increment; the other half
                // holds its current value and no carry crosses halves.
                A_MCYCLE:    mcycle_d   = {mcycle_q[CNT_W-1:32], new_val};
                A_MCYCLEH:   mcycle_d   = {new_val, mcycle_q[31:0]};
                A_MINSTRET:  minstret_d = {minstret_q[CNT_W-1:32], new_val};
                A_MINSTRETH: minstret_d = {new_val, minstret_q[31:0]};
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            req_addr_q    <= 12'h0;
            req_op_q      <= OP_NONE;
            req_src_q     <= 32'h0;
            req_zero_q    <= 1'b0;
            mstatus_q     <= 32'h0;
            mie_q         <= 32'h0;
            mtvec_q       <= RESET_MTVEC & M_MTVEC;
            mscratch_q    <= 32'h0;
            mepc_q        <= 32'h0;
            mcause_q      <= 32'h0;
            mtval_q       <= 32'h0;
            mcycle_q      <= '0;
            minstret_q    <= '0;
            cycle_o_q     <= '0;
            instret_o_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_addr_q    <= req_addr_d;
            req_op_q      <= req_op_d;
            req_src_q     <= req_src_d;
            req_zero_q    <= req_zero_d;
            mstatus_q     <= mstatus_d;
            mie_q         <= mie_d;
            mtvec_q       <= mtvec_d;
            mscratch_q    <= mscratch_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mtval_q       <= mtval_d;
            mcycle_q      <= mcycle_d;
            minstret_q    <= minstret_d;
            cycle_o_q     <= cycle_o_d;
            instret_o_q   <= instret_o_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_illegal = rsp_illegal_q;
    assign cycle_o     = cycle_o_q;
    assign instret_o   = instret_o_q;

endmodule

// File: tb/tb_csr_write_unit.sv
// -----------------------------------------------------------------------------
// tb_csr_write_unit
//   Directed plus randomized checks of csr_write_unit against a table-driven
//   reference model (address -> stored value / write mask). Counter behaviour
//   is checked through cycle_o / instret_o.
// -----------------------------------------------------------------------------
module tb_csr_write_unit;

    localparam logic [31:0] TB_MTVEC = 32'h8000_0103;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] csr_addr;
    logic [2:0]  csr_funct3;
    logic [31:0] csr_src;
    logic        src_is_zero;
    logic        inc_instret;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;
    logic [63:0] cycle_o;
    logic [63:0] instret_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_val  [int];
    logic [31:0] m_mask [int];

    logic [31:0] last_rd;
    logic [63:0] cyc_at_rsp, cyc_after, ins_at_rsp;
    logic [63:0] instret_m;

    csr_write_unit #(.RESET_MTVEC(TB_MTVEC), .CNT_W(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .csr_addr(csr_addr), .csr_funct3(csr_funct3), .csr_src(csr_src),
        .src_is_zero(src_is_zero), .inc_instret(inc_instret),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal),
        .cycle_o(cycle_o), .instret_o(instret_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural state after reset, expressed as address -> (value, mask).
    task automatic model_reset();
        m_val.delete();
        m_mask.delete();
        m_mask[12'h300] = 32'h0000_0088;
        m_mask[12'h304] = 32'h0000_0888;
        m_mask[12'h305] = 32'hFFFF_FFFD;
        m_mask[12'h340] = 32'hFFFF_FFFF;
        m_mask[12'h341] = 32'hFFFF_FFFC;
        m_mask[12'h342] = 32'hFFFF_FFFF;
        m_mask[12'h343] = 32'hFFFF_FFFF;
`ifdef CSR_COUNTER_WRITE_EN
        m_mask[12'hB00] = 32'hFFFF_FFFF;
        m_mask[12'hB80] = 32'hFFFF_FFFF;
        m_mask[12'hB02] = 32'hFFFF_FFFF;
        m_mask[12'hB82] = 32'hFFFF_FFFF;
`endif
        foreach (m_mask[a]) m_val[a] = 32'h0;
        m_val[12'h305] = TB_MTVEC & 32'hFFFF_FFFD;
    endtask

    task automatic model_exec(input logic [11:0] a, input logic [2:0] f3,
                              input logic [31:0] src, input bit zero,
                              output logic [31:0] rd, output bit ill);
        bit          wr;
        logic [31:0] nv;
        int          key;
        key = int'(a);
        wr  = (f3[1:0] == 2'b01) || !zero;
        ill = !m_mask.exists(key) || (f3[1:0] == 2'b00) || (wr && a[11:10] == 2'b11);
        rd  = 32'h0;
        if (!ill) begin
            rd = m_val[key];
            if (wr) begin
                if (f3[1:0] == 2'b01)      nv = src;
                else if (f3[1:0] == 2'b10) nv = rd | src;
                else                       nv = rd & ~src;
                m_val[key] = nv & m_mask[key];
            end
        end
    endtask

    // One request: accept, then expect the response pulse at the 3rd falling
    // edge after the accept edge (i.e. 2 cycles after the accept edge).
    task automatic issue(input logic [11:0] a, input logic [2:0] f3, input logic [31:0] src,
                         input bit zero, input bit chk_rd, input bit inc_exec);
        logic [31:0] erd;
        bit          eill;
        int          k;
        model_exec(a, f3, src, zero, erd, eill);
        @(negedge clk);
        check("ready_idle", {63'h0, req_ready}, 64'h1);
        req_valid   = 1'b1;
        csr_addr    = a;
        csr_funct3  = f3;
        csr_src     = src;
        src_is_zero = zero;
        k = 0;
        while (k < 8) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                req_valid   = 1'b0;
                inc_instret = inc_exec;
                check("ready_busy", {63'h0, req_ready}, 64'h0);
            end else if (k == 2) begin
                inc_instret = 1'b0;
            end
            if (rsp_valid === 1'b1) break;
        end
        check("rsp_latency", 64'(k), 64'd3);
        check("rsp_illegal", {63'h0, rsp_illegal}, {63'h0, eill});
        if (chk_rd) check("rsp_rdata", {32'h0, rsp_rdata}, {32'h0, erd});
        last_rd    = rsp_rdata;
        cyc_at_rsp = cycle_o;
        ins_at_rsp = instret_o;
        @(negedge clk);
        check("rsp_pulse", {63'h0, rsp_valid}, 64'h0);
        cyc_after = cycle_o;
    endtask

    initial begin
        logic [11:0] alist [10];
        logic [63:0] c0;
        logic [11:0] a;
        logic [2:0]  f3;
        logic [31:0] src;
        bit          zero;
        bit          seen;

        alist = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                  12'h342, 12'h343, 12'h344, 12'h7FF, 12'hC00};

        reset = 1'b1; req_valid = 1'b0; csr_addr = 12'h0; csr_funct3 = 3'h0;
        csr_src = 32'h0; src_is_zero = 1'b0; inc_instret = 1'b0;
        instret_m = 64'h0;
        last_rd = 32'h0; cyc_at_rsp = 64'h0; cyc_after = 64'h0; ins_at_rsp = 64'h0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready",   {63'h0, req_ready},   64'h1);
        check("rst_valid",   {63'h0, rsp_valid},   64'h0);
        check("rst_rdata",   {32'h0, rsp_rdata},   64'h0);
        check("rst_illegal", {63'h0, rsp_illegal}, 64'h0);
        check("rst_cycle",   cycle_o,   64'h0);
        check("rst_instret", instret_o, 64'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("cycle_after_5", cycle_o, 64'd4);

        // mtvec reset value with bit 1 cleared
        issue(12'h305, 3'b010, 32'h0, 1'b1, 1'b1, 1'b0);
        check("mtvec_reset", {32'h0, last_rd}, 64'h8000_0101);

        // mscratch write then pure read
        issue(12'h340, 3'b001, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        check("mscratch_old", {32'h0, last_rd}, 64'h0);
        issue(12'h340, 3'b010, 32'h0, 1'b1, 1'b1, 1'b0);
        check("mscratch_rd", {32'h0, last_rd}, 64'hDEADBEEF);

        // mstatus masking
        issue(12'h300, 3'b001, 32'h0, 1'b1, 1'b1, 1'b0);
        issue(12'h300, 3'b010, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        check("mstatus_old0", {32'h0, last_rd}, 64'h0);
        issue(12'h300, 3'b011, 32'h8, 1'b0, 1'b1, 1'b0);
        check("mstatus_88", {32'h0, last_rd}, 64'h88);
        issue(12'h300, 3'b010, 32'h0, 1'b1, 1'b1, 1'b0);
        check("mstatus_80", {32'h0, last_rd}, 64'h80);

        // mepc / mtvec low-bit masking
        issue(12'h341, 3'b101, 32'h1F, 1'b0, 1'b1, 1'b0);
        issue(12'h341, 3'b110, 32'h0, 1'b1, 1'b1, 1'b0);
        check("mepc_1c", {32'h0, last_rd}, 64'h1C);
        issue(12'h305, 3'b001, 32'h7, 1'b0, 1'b1, 1'b0);
        issue(12'h305, 3'b010, 32'h0, 1'b1, 1'b1, 1'b0);
        check("mtvec_5", {32'h0, last_rd}, 64'h5);

        // Illegal cases leave state untouched
        issue(12'hC00, 3'b001, 32'h1234, 1'b0, 1'b1, 1'b0);
        issue(12'h340, 3'b100, 32'h5555, 1'b0, 1'b1, 1'b0);
        issue(12'h7FF, 3'b010, 32'h0, 1'b1, 1'b1, 1'b0);
`ifndef CSR_COUNTER_WRITE_EN
        issue(12'hB00, 3'b010, 32'h0, 1'b1, 1'b1, 1'b0);
`endif
        issue(12'h340, 3'b010, 32'h0, 1'b1, 1'b1, 1'b0);
        check("mscratch_kept", {32'h0, last_rd}, 64'hDEADBEEF);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            a  = alist[$urandom_range(0, 9)];
            f3 = 3'($urandom_range(0, 7));
            src = $urandom;
            if (f3[2]) src = src & 32'h1F;
            if ($urandom_range(0, 3) == 0) src = 32'h0;
            zero = (src == 32'h0);
            issue(a, f3, src, zero, 1'b1, 1'b0);
        end

        // mcycle advances once per clock
        @(negedge clk);
        c0 = cycle_o;
        repeat (37) @(negedge clk);
        check("cycle_delta", cycle_o - c0, 64'd37);

        // minstret counts retire pulses
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            inc_instret = 1'($urandom_range(0, 1));
            if (inc_instret) instret_m = instret_m + 64'd1;
        end
        @(negedge clk);
        inc_instret = 1'b0;
        repeat (2) @(negedge clk);
        check("instret_count", instret_o, instret_m);

`ifdef CSR_COUNTER_WRITE_EN
        // High half first so the low-half write lands on all-ones, then wraps.
        issue(12'hB80, 3'b001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        issue(12'hB00, 3'b001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        check("cycle_allones", cyc_at_rsp, 64'hFFFF_FFFF_FFFF_FFFF);
        check("cycle_wrap", cyc_after, 64'h0);
        // Write coinciding with a retire pulse: the write wins.
        issue(12'hB02, 3'b001, 32'h1234, 1'b0, 1'b0, 1'b1);
        check("instret_wr_wins", ins_at_rsp, 64'h1234);
`endif

        // Reset asserted during EXEC aborts the operation
        @(negedge clk);
        req_valid = 1'b1; csr_addr = 12'h340; csr_funct3 = 3'b001;
        csr_src = 32'hCAFEF00D; src_is_zero = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        check("abort_no_rsp", {63'h0, seen}, 64'h0);
        check("abort_ready", {63'h0, req_ready}, 64'h1);
        issue(12'h340, 3'b010, 32'h0, 1'b1, 1'b1, 1'b0);
        check("abort_mscratch", {32'h0, last_rd}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
